// File: rtl/alu_multiplier_if.sv
// Multiply-path handshake bundle: start/operands in, busy/done/hi/lo back.
// Backpressure is start/busy only; the caller holds start until it sees acceptance.
interface alu_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/alu_multiplier.sv
// Radix-4 Booth signed multiplier, one digit per clock; result WIDTH/2 edges after acceptance.
// No queueing: start is ignored while busy, accepted again only in IDLE or the DONE cycle.
module alu_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clr,
    alu_multiplier_if.slave       bus
);
    localparam int STEPS = WIDTH / 2;
    localparam int AW    = WIDTH + 2;
    localparam int RW    = AW + WIDTH;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    prod_q, prod_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2:0]       triplet;
    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum;
    logic [RW-1:0]    step_prod;

    // Booth digit selection and one accumulate-then-shift step.
    always_comb begin
        triplet = {prod_q[1], prod_q[0], qm1_q};
        m_ext   = {{2{m_q[WIDTH-1]}}, m_q};
        addend  = '0;
        case (triplet)
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum       = prod_q[RW-1:WIDTH] + addend;
        step_prod = {{2{sum[AW-1]}}, sum, prod_q[WIDTH-1:2]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    m_d     = bus.multiplicand;
                    prod_d  = {{AW{1'b0}}, bus.multiplier};
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                prod_d = step_prod;
                qm1_d  = prod_q[1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    hi_d    = step_prod[2*WIDTH-1:WIDTH];
                    lo_d    = step_prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_alu_multiplier.sv
// Directed and random checks of the Booth multiplier against plain 64-bit signed multiplication.
module tb_alu_multiplier;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_multiplier_if #(.WIDTH(32)) bus ();
    alu_multiplier #(.WIDTH(32)) dut (.clk(clk), .clr(clr), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q);
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return p;
    endfunction

    // Waits for done from the first negedge after acceptance; returns edges elapsed.
    task automatic wait_done(output int k, output int gaps, input bit scramble);
        k = 0;
        gaps = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            if (bus.busy !== 1'b1) gaps++;
            if (scramble && k == 3) begin
                bus.multiplicand = $urandom;
                bus.multiplier   = $urandom;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q);
        logic [63:0] exp;
        int k, gaps;
        exp = model(m, q);
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        @(negedge clk);
        check({tag, ".busy_at_accept"}, 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(k, gaps, 1'b1);
        check({tag, ".latency"}, 64'(k), 64'd16);
        check({tag, ".busy_gaps"}, 64'(gaps), 64'd0);
        check({tag, ".busy_low_in_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".product"}, {bus.hi, bus.lo}, exp);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int k, gaps, pulses, busy_seen;
        logic [31:0] rm, rq;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        clr = 1'b0;

        run_op("m7q3", 32'd7, 32'd3);
        check("m7q3.const", {bus.hi, bus.lo}, 64'h0000_0000_0000_0015);
        run_op("mn7q3", 32'hFFFF_FFF9, 32'd3);
        check("mn7q3.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("minsq", 32'h8000_0000, 32'h8000_0000);
        check("minsq.const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
        run_op("neg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("neg1sq.const", {bus.hi, bus.lo}, 64'd1);
        run_op("maxmin", 32'h7FFF_FFFF, 32'h8000_0000);

        // start during RUN is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd5; bus.multiplier = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                check("ignore.product", {bus.hi, bus.lo}, 64'd30);
            end
            @(negedge clk);
        end
        check("ignore.pulses", 64'(pulses), 64'd1);

        // clr mid-run aborts, clears hi/lo, drops a concurrent start
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd123; bus.multiplier = 32'd456;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        clr = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        clr = 1'b0; bus.start = 1'b0;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.hilo", {bus.hi, bus.lo}, 64'd0);
        pulses = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) pulses++;
            if (bus.busy === 1'b1) busy_seen++;
            @(negedge clk);
        end
        check("abort.no_done", 64'(pulses), 64'd0);
        check("abort.stays_idle", 64'(busy_seen), 64'd0);

        // back-to-back with start held through DONE
        bus.start = 1'b1; bus.multiplicand = 32'd2; bus.multiplier = 32'd3;
        @(negedge clk);
        wait_done(k, gaps, 1'b0);
        check("b2b.first_latency", 64'(k), 64'd16);
        check("b2b.first_product", {bus.hi, bus.lo}, 64'd6);
        bus.multiplicand = 32'hFFFF_FFFF; bus.multiplier = 32'd5;
        @(negedge clk);
        check("b2b.busy_again", 64'(bus.busy), 64'd1);
        check("b2b.done_dropped", 64'(bus.done), 64'd0);
        check("b2b.hilo_kept", {bus.hi, bus.lo}, 64'd6);
        bus.start = 1'b0;
        wait_done(k, gaps, 1'b0);
        check("b2b.second_latency", 64'(k), 64'd16);
        check("b2b.second_product", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFB);
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            rm = $urandom;
            rq = $urandom;
            if (i % 5 == 0) rm = 32'(rm[7:0]) - 32'd128;
            run_op($sformatf("rand%0d", i), rm, rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
